// File: rtl/mux_pkg.sv
// Shared constants and FSM state type for the 8:1 serial link receive side.
package mux_pkg;

    localparam int MUX_WIDTH = 8;
    localparam int MUX_SEL_W = 3;

    // IDLE: auto mode, nothing held. COLLECT: auto mode, partial word held.
    // DIRECT: caller-indexed demux (auto_mode=0).
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DIRECT  = 2'd2
    } demux_state_t;

endpackage

// File: rtl/demux_bit_decoder.sv
// Combinational index -> one-hot write-enable decoder shared by the
// shadow (auto assembly) and dout (direct demux) write paths.
module demux_bit_decoder
    import mux_pkg::*;
#(
    parameter int WIDTH = MUX_WIDTH,
    parameter int SEL_W = $clog2(WIDTH)
) (
    input  logic [SEL_W-1:0] i_sel,
    output logic [WIDTH-1:0] o_onehot
);

    // One compare per output position.
    for (genvar g = 0; g < WIDTH; g++) begin : g_dec
        assign o_onehot[g] = (i_sel == SEL_W'(g));
    end

endmodule

// File: rtl/demux_deserializer.sv
// Serial-to-parallel receiver: auto mode assembles WIDTH bits LSB-first
// into a word; direct mode writes single dout bits at a caller-given index.
module demux_deserializer
    import mux_pkg::*;
#(
    parameter int WIDTH = MUX_WIDTH,
    parameter int SEL_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             auto_mode,
    input  logic [SEL_W-1:0] sel_in,
    input  logic             clear,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic [SEL_W-1:0] bit_idx,
    output logic             busy
);

    demux_state_t     r_state, w_next_state;
    logic [SEL_W-1:0] r_bit_idx, w_next_idx;
    logic [WIDTH-1:0] r_shadow, w_next_shadow;
    logic [WIDTH-1:0] r_dout, w_next_dout;
    logic             r_dout_valid, w_next_dv;

    // A mode change discards any partial word; the din arriving in the
    // same cycle is then handled from a clean slate in the new mode.
    logic             w_mode_chg;
    demux_state_t     w_state_base;
    logic [SEL_W-1:0] w_idx_base;
    logic [WIDTH-1:0] w_shadow_base;

    assign w_mode_chg    = auto_mode ? (r_state == DIRECT) : (r_state != DIRECT);
    assign w_state_base  = w_mode_chg ? IDLE : r_state;
    assign w_idx_base    = w_mode_chg ? '0 : r_bit_idx;
    assign w_shadow_base = w_mode_chg ? '0 : r_shadow;

    // Single write decoder: auto mode indexes by the counter, direct by sel_in.
    logic [SEL_W-1:0] w_wr_sel;
    logic [WIDTH-1:0] w_wr_onehot;
    logic [WIDTH-1:0] w_din_mask;
    logic [WIDTH-1:0] w_shadow_wr;
    logic [WIDTH-1:0] w_dout_wr;
    logic             w_last_bit;

    assign w_wr_sel = auto_mode ? w_idx_base : sel_in;

    demux_bit_decoder #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_dec (
        .i_sel    (w_wr_sel),
        .o_onehot (w_wr_onehot)
    );

    assign w_din_mask  = din ? w_wr_onehot : '0;
    // At the last index this equals {din, shadow[WIDTH-2:0]}.
    assign w_shadow_wr = (w_shadow_base & ~w_wr_onehot) | w_din_mask;
    assign w_dout_wr   = (r_dout & ~w_wr_onehot) | w_din_mask;
    assign w_last_bit  = (w_idx_base == SEL_W'(WIDTH - 1));

    // Next-state / datapath decisions; priority clear > mode change > din_valid.
    always_comb begin
        w_next_state  = r_state;
        w_next_idx    = r_bit_idx;
        w_next_shadow = r_shadow;
        w_next_dout   = r_dout;
        w_next_dv     = 1'b0;
        if (clear) begin
            w_next_state  = auto_mode ? IDLE : DIRECT;
            w_next_idx    = '0;
            w_next_shadow = '0;
        end else if (!auto_mode) begin
            w_next_state  = DIRECT;
            w_next_idx    = '0;
            w_next_shadow = '0;
            if (din_valid) begin
                w_next_dout = w_dout_wr;
                w_next_dv   = 1'b1;
            end
        end else begin
            w_next_state  = w_state_base;
            w_next_idx    = w_idx_base;
            w_next_shadow = w_shadow_base;
            if (din_valid) begin
                if (w_last_bit) begin
                    w_next_dout   = w_shadow_wr;
                    w_next_dv     = 1'b1;
                    w_next_idx    = '0;
                    w_next_shadow = '0;
                    w_next_state  = IDLE;
                end else begin
                    w_next_shadow = w_shadow_wr;
                    w_next_idx    = w_idx_base + SEL_W'(1);
                    w_next_state  = COLLECT;
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // Index counter, shadow word and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_idx    <= '0;
            r_shadow     <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_bit_idx    <= w_next_idx;
            r_shadow     <= w_next_shadow;
            r_dout       <= w_next_dout;
            r_dout_valid <= w_next_dv;
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign bit_idx    = r_bit_idx;
    assign busy       = (r_state == COLLECT);

endmodule

// File: tb/tb_demux_deserializer.sv
// Directed bench: stimulus pushes expected (word, strobe edge) into a queue;
// a negedge monitor pops and compares on every dout_valid.
module tb_demux_deserializer;

    localparam int WIDTH = 8;
    localparam int SEL_W = 3;

    logic             clk = 1'b0;
    logic             rst, din, din_valid, auto_mode, clear;
    logic [SEL_W-1:0] sel_in;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic [SEL_W-1:0] bit_idx;
    logic             busy;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               edge_no;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   edge_cnt = 0;

    demux_deserializer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .auto_mode  (auto_mode),
        .sel_in     (sel_in),
        .clear      (clear),
        .dout       (dout),
        .dout_valid (dout_valid),
        .bit_idx    (bit_idx),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (dout_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", {24'd0, dout}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("word_data", {24'd0, dout}, {24'd0, e.data});
                chk("strobe_edge", edge_cnt, e.edge_no);
            end
        end
    end

    // Next posedge captures the inputs; its strobe is seen after that edge.
    task automatic push(input logic [WIDTH-1:0] w);
        exp_t e;
        e.data    = w;
        e.edge_no = edge_cnt + 1;
        exp_q.push_back(e);
    endtask

    task automatic send_bits(input logic [WIDTH-1:0] w, input int n, input bit expect_word);
        for (int i = 0; i < n; i++) begin
            din       = w[i];
            din_valid = 1'b1;
            if (expect_word && i == WIDTH - 1) push(w);
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic direct_wr(input logic [SEL_W-1:0] s, input logic b, input logic [WIDTH-1:0] exp_word);
        sel_in    = s;
        din       = b;
        din_valid = 1'b1;
        push(exp_word);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; din = 1'b0; din_valid = 1'b0; auto_mode = 1'b1;
        clear = 1'b0; sel_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_dout", {24'd0, dout}, 32'h00);
        chk("rst_idx", {29'd0, bit_idx}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, dout_valid}, 32'd0);
        rst = 1'b0;

        // Single word 0xA5.
        send_bits(8'hA5, 8, 1'b1);
        idle(2);
        chk("a5_dout_hold", {24'd0, dout}, 32'hA5);

        // Reset in the middle of a word.
        send_bits(8'hFF, 3, 1'b0);
        chk("mid_idx", {29'd0, bit_idx}, 32'd3);
        rst = 1'b1;
        idle(2);
        chk("midrst_dout", {24'd0, dout}, 32'h00);
        chk("midrst_idx", {29'd0, bit_idx}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_valid", {31'd0, dout_valid}, 32'd0);
        rst = 1'b0;

        // Back-to-back words.
        send_bits(8'h3C, 8, 1'b1);
        send_bits(8'hFF, 8, 1'b1);
        idle(2);

        // Stall then clear.
        send_bits(8'h0F, 4, 1'b0);
        idle(5);
        chk("stall_idx", {29'd0, bit_idx}, 32'd4);
        chk("stall_busy", {31'd0, busy}, 32'd1);
        chk("stall_dout", {24'd0, dout}, 32'hFF);
        clear = 1'b1; din = 1'b1; din_valid = 1'b1;
        @(negedge clk);
        clear = 1'b0; din_valid = 1'b0;
        chk("clr_idx", {29'd0, bit_idx}, 32'd0);
        chk("clr_busy", {31'd0, busy}, 32'd0);
        chk("clr_dout", {24'd0, dout}, 32'hFF);
        send_bits(8'h81, 8, 1'b1);
        idle(2);

        // Direct mode from a cleared dout.
        rst = 1'b1; auto_mode = 1'b0;
        idle(2);
        rst = 1'b0;
        direct_wr(3'd5, 1'b1, 8'h20);
        direct_wr(3'd2, 1'b1, 8'h24);
        direct_wr(3'd5, 1'b0, 8'h04);
        idle(1);
        chk("dir_idx", {29'd0, bit_idx}, 32'd0);
        chk("dir_busy", {31'd0, busy}, 32'd0);

        // Mode toggles discard partial words.
        auto_mode = 1'b1;
        send_bits(8'hFF, 3, 1'b0);
        chk("tog_idx3", {29'd0, bit_idx}, 32'd3);
        chk("tog_busy3", {31'd0, busy}, 32'd1);
        auto_mode = 1'b0;
        idle(1);
        chk("tog_idx0", {29'd0, bit_idx}, 32'd0);
        chk("tog_busy0", {31'd0, busy}, 32'd0);
        chk("tog_dout", {24'd0, dout}, 32'h04);
        auto_mode = 1'b1;
        send_bits(8'h5A, 8, 1'b1);
        idle(3);
        chk("final_dout", {24'd0, dout}, 32'h5A);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
